pe_psum_collector: RTL and testbench

Receive-side block for the 11x11 PE product bus. Each accepted beat reduces the top-left KxK window of the 2*DataWidth-bit signed products through a two-stage registered adder tree. The block accumulates C consecutive window sums (one per input channel) and delivers one partial-sum result per group on a valid/ready output. It sits directly downstream of the PE matrix and upstream of the output-feature buffer.

---
 rtl/pe_psum_collector.sv | 129 ++++++++++++
 tb/tb_pe_psum_collector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_psum_collector.sv
// Partial-sum collector for the 11x11 PE product bus: KxK window reduction through a
// two-stage adder tree, accumulated over C channels and delivered on a valid/ready port.
module pe_psum_collector #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned AccWidth  = 2*DataWidth+8
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic                                  clr,
   input  logic [3:0]                            cfg_k,
   input  logic [7:0]                            cfg_c,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [10:0][10:0][2*DataWidth-1:0]    Bus_P,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [AccWidth-1:0]                   out_data,
   output logic                                  busy
);

   localparam int unsigned PW = 2*DataWidth;

   logic                en, accept, first, last;
   logic [3:0]          k_eff, k_q, k_use;
   logic [7:0]          c_eff, c_q, c_use, count_q;
   logic [AccWidth-1:0] colsum_d [11];
   logic [AccWidth-1:0] colsum_q [11];
   logic                s1_valid_q, s1_first_q, s1_last_q;
   logic [AccWidth-1:0] win_d, win_q;
   logic                s2_valid_q, s2_first_q, s2_last_q;
   logic [AccWidth-1:0] acc_q, sum;
   logic                out_valid_q;
   logic [AccWidth-1:0] out_data_q;

   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = en;
   assign accept   = in_valid && en;

   always_comb begin
      k_eff = (cfg_k == 4'd0) ? 4'd1 : ((cfg_k > 4'd11) ? 4'd11 : cfg_k);
      c_eff = (cfg_c == 8'd0) ? 8'd1 : cfg_c;
      first = (count_q == 8'd0);
      // Configuration is only sampled at the start of a group.
      k_use = first ? k_eff : k_q;
      c_use = first ? c_eff : c_q;
      last  = (count_q == c_use - 8'd1);
   end

   always_comb begin
      for (int c = 0; c < 11; c++) begin
         colsum_d[c] = '0;
         for (int r = 0; r < 11; r++) begin
            if (c < int'(k_use) && r < int'(k_use)) begin
               colsum_d[c] = colsum_d[c] + {{(AccWidth-PW){Bus_P[c][r][PW-1]}}, Bus_P[c][r]};
            end
         end
      end
   end

   always_comb begin
      win_d = '0;
      for (int c = 0; c < 11; c++) begin
         win_d = win_d + colsum_q[c];
      end
   end

   assign sum = s2_first_q ? win_q : acc_q + win_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         k_q         <= '0;
         c_q         <= '0;
         count_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         for (int c = 0; c < 11; c++) colsum_q[c] <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         win_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (clr) begin
         k_q         <= '0;
         c_q         <= '0;
         count_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         for (int c = 0; c < 11; c++) colsum_q[c] <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         win_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (en) begin
         if (accept) begin
            if (first) begin
               k_q <= k_eff;
               c_q <= c_eff;
            end
            count_q <= last ? 8'd0 : count_q + 8'd1;
         end
         s1_valid_q <= accept;
         s1_first_q <= first;
         s1_last_q  <= last;
         for (int c = 0; c < 11; c++) colsum_q[c] <= colsum_d[c];
         s2_valid_q <= s1_valid_q;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         win_q      <= win_d;
         if (s2_valid_q) begin
            acc_q <= sum;
            if (s2_last_q) out_data_q <= sum;
         end
         // en high means the held result (if any) is being taken this cycle.
         out_valid_q <= s2_valid_q && s2_last_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (count_q != 8'd0) || s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_pe_psum_collector.sv
// Directed bench for pe_psum_collector with a queue-based group-sum model checked every cycle.
module tb_pe_psum_collector;

   logic                        CLK = 1'b0;
   logic                        RST = 1'b0;
   logic                        clr = 1'b0;
   logic [3:0]                  cfg_k = 4'd3;
   logic [7:0]                  cfg_c = 8'd1;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [10:0][10:0][31:0]     bus;
   logic                        out_valid;
   logic                        out_ready = 1'b1;
   logic [39:0]                 out_data;
   logic                        busy;

   int checks = 0;
   int passes = 0;

   pe_psum_collector #(.DataWidth(16), .AccWidth(40)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (clr),
      .cfg_k     (cfg_k),
      .cfg_c     (cfg_c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Bus_P     (bus),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic logic [39:0] v40(input int v);
      return 40'(v);
   endfunction

   // Behavioural model: group sums computed straight from the window definition.
   logic [39:0] mq[$];
   int          m_count = 0;
   int          m_k = 1;
   int          m_c = 1;
   logic [39:0] m_acc = '0;

   function automatic logic [39:0] window_sum(input int k);
      logic [39:0] s = '0;
      for (int c = 0; c < k; c++)
         for (int r = 0; r < k; r++)
            s = s + {{8{bus[c][r][31]}}, bus[c][r]};
      return s;
   endfunction

   task automatic model_flush();
      mq.delete();
      m_count = 0;
      m_acc   = '0;
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         chk("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
         if (out_valid) begin
            chk("result_expected", {63'd0, mq.size() != 0}, 64'd1);
            if (mq.size() != 0) chk("out_data_model", {24'd0, out_data}, {24'd0, mq[0]});
         end
         if (clr) model_flush();
         else begin
            if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
            if (in_valid && in_ready) begin
               if (m_count == 0) begin
                  m_k   = (cfg_k == 0) ? 1 : ((cfg_k > 11) ? 11 : int'(cfg_k));
                  m_c   = (cfg_c == 0) ? 1 : int'(cfg_c);
                  m_acc = window_sum(m_k);
               end else begin
                  m_acc = m_acc + window_sum(m_k);
               end
               m_count++;
               if (m_count == m_c) begin
                  mq.push_back(m_acc);
                  m_count = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_bus(input int k, input int win_val, input int out_val);
      for (int c = 0; c < 11; c++)
         for (int r = 0; r < 11; r++)
            bus[c][r] = (c < k && r < k) ? 32'(win_val) : 32'(out_val);
   endtask

   task automatic send();
      int n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL accept_timeout: got in_ready=0 after %0d cycles required 1", n);
      end else begin
         tick();
      end
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic reset_pulse();
      RST = 1'b0;
      model_flush();
      tick();
      RST = 1'b1;
      tick();
   endtask

   int lat;

   initial begin
      set_bus(11, 1, 1);
      tick();
      tick();
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_out_data", {24'd0, out_data}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      RST = 1'b1;
      tick();

      // K=3, C=1 single beat
      cfg_k = 4'd3; cfg_c = 8'd1; set_bus(11, 1, 1);
      send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t1_latency", 64'(lat), 64'd2);
      chk("t1_data", {24'd0, out_data}, {24'd0, v40(9)});
      tick();
      chk("t1_valid_drop", {63'd0, out_valid}, 64'd0);

      // K=11, C=4, all +2
      cfg_k = 4'd11; cfg_c = 8'd4; set_bus(11, 2, 2);
      send(); send();
      chk("t2_busy_mid", {63'd0, busy}, 64'd1);
      send(); send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t2_latency", 64'(lat), 64'd2);
      chk("t2_data", {24'd0, out_data}, {24'd0, v40(968)});
      tick();
      chk("t2_valid_drop", {63'd0, out_valid}, 64'd0);

      // K=2, C=2, -5 inside, +1000 outside
      cfg_k = 4'd2; cfg_c = 8'd2; set_bus(2, -5, 1000);
      send(); send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t3_data", {24'd0, out_data}, {24'd0, v40(-40)});
      tick();

      // Back-to-back with a 5-cycle consumer stall
      out_ready = 1'b0;
      cfg_k = 4'd3; cfg_c = 8'd1; set_bus(11, 1, 1);
      send(); send(); in_valid = 1'b0;
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("t4_stall_valid", {63'd0, out_valid}, 64'd1);
         chk("t4_stall_data", {24'd0, out_data}, {24'd0, v40(9)});
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("t4_second_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_second_data", {24'd0, out_data}, {24'd0, v40(9)});
      tick();
      chk("t4_drained", {63'd0, out_valid}, 64'd0);
      chk("t4_idle", {63'd0, busy}, 64'd0);

      // Clamping: K=15 -> 11, C=0 -> 1; then K=0 -> 1
      cfg_k = 4'd15; cfg_c = 8'd0; set_bus(11, 1, 1);
      send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t5_k15_data", {24'd0, out_data}, {24'd0, v40(121)});
      tick();
      cfg_k = 4'd0; cfg_c = 8'd1; set_bus(11, 1, 1); bus[0][0] = 32'd7;
      send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t5_k0_data", {24'd0, out_data}, {24'd0, v40(7)});
      tick();

      // Config latched on the first beat of a group
      cfg_k = 4'd3; cfg_c = 8'd2; set_bus(11, 1, 1);
      send();
      cfg_k = 4'd11; cfg_c = 8'd1;
      send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t5_latch_data", {24'd0, out_data}, {24'd0, v40(18)});
      tick();

      // clr after 2 of 4 beats, with a beat presented during clr
      cfg_k = 4'd3; cfg_c = 8'd4; set_bus(11, 1, 1);
      send(); send();
      clr = 1'b1;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      chk("t6_clr_busy", {63'd0, busy}, 64'd0);
      chk("t6_clr_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_clr_in_ready", {63'd0, in_ready}, 64'd1);
      send(); send(); send(); send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t6_clr_latency", 64'(lat), 64'd2);
      chk("t6_clr_data", {24'd0, out_data}, {24'd0, v40(36)});
      tick();

      // Reset after 2 of 4 beats
      send(); send(); in_valid = 1'b0;
      reset_pulse();
      chk("t6_rst_busy", {63'd0, busy}, 64'd0);
      send(); send(); send(); send(); in_valid = 1'b0;
      wait_out(lat);
      chk("t6_rst_latency", 64'(lat), 64'd2);
      chk("t6_rst_data", {24'd0, out_data}, {24'd0, v40(36)});
      tick();
      tick();

      chk("all_results_delivered", 64'(mq.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
